// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding and constants for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters with streak-limited data priority
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic grant_d, grant_i, done;
  logic [DW-1:0] resp_data;
  // data wins unless fetch has already waited out a full streak
  always_comb begin
    grant_d = d_req && !(i_req && streak == SW'(MAX_D_STREAK));
    grant_i = i_req && !grant_d;
    done = mem_ack || tcnt == TW'(TIMEOUT - 1);
    resp_data = mem_ack ? mem_rdata : DW'(TIMEOUT_DATA);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      streak <= '0;
      tcnt <= '0;
      i_ack <= 1'b0;
      i_rdata <= '0;
      d_ack <= 1'b0;
      d_rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (grant_d) begin
            state <= BUSY_D;
            mem_req <= 1'b1;
            mem_we <= d_we;
            mem_be <= d_be;
            mem_addr <= d_addr;
            mem_wdata <= d_wdata;
            streak <= i_req ? streak + SW'(1) : '0;
          end else if (grant_i) begin
            state <= BUSY_I;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_be <= 4'hF;
            mem_addr <= i_addr;
            mem_wdata <= '0;
            streak <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          tcnt <= tcnt + TW'(1);
          if (done) begin
            state <= RESP;
            mem_req <= 1'b0;
            err <= err | !mem_ack;
            if (state == BUSY_I) begin
              i_ack <= 1'b1;
              i_rdata <= resp_data;
            end else begin
              d_ack <= 1'b1;
              d_rdata <= resp_data;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          i_ack <= 1'b0;
          d_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_mem_port_arbiter;
  localparam int TO = 255;
  localparam int LAT = 3;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [3:0] d_be = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic mem_ack = 0;
  logic i_ack, d_ack, mem_req, mem_we, err;
  logic [3:0] mem_be;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference model: one outstanding transaction, owner 1 = fetch, 2 = data
  bit m_valid = 0, m_resp = 0;
  logic m_req = 0, m_we = 0, m_iack = 0, m_dack = 0, m_err = 0;
  logic [3:0] m_be = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_ir = 0, m_dr = 0, m_v = 0;
  int m_owner = 0, m_wait = 0, m_streak = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_resp = 0; m_req = 0; m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
      m_iack = 0; m_dack = 0; m_err = 0; m_ir = 0; m_dr = 0; m_owner = 0; m_wait = 0; m_streak = 0;
    end else if (m_resp) begin
      m_iack = 0; m_dack = 0; m_resp = 0;
    end else if (m_req) begin
      m_wait++;
      if (mem_ack || m_wait == TO) begin
        m_v = mem_ack ? mem_rdata : 32'hDEADBEEF;
        if (!mem_ack) m_err = 1;
        m_req = 0; m_resp = 1;
        if (m_owner == 1) begin m_iack = 1; m_ir = m_v; end
        else begin m_dack = 1; m_dr = m_v; end
      end
    end else if (d_req && !(i_req && m_streak >= 4)) begin
      m_owner = 2; m_req = 1; m_wait = 0;
      m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
      m_streak = i_req ? m_streak + 1 : 0;
    end else if (i_req) begin
      m_owner = 1; m_req = 1; m_wait = 0;
      m_we = 0; m_be = 4'hF; m_addr = i_addr;
      m_streak = 0;
    end
  end

  always @(negedge clk) if (m_valid) begin
    chk("mem_req", 64'(mem_req), 64'(m_req));
    chk("i_ack", 64'(i_ack), 64'(m_iack));
    chk("d_ack", 64'(d_ack), 64'(m_dack));
    chk("err", 64'(err), 64'(m_err));
    chk("i_rdata", 64'(i_rdata), 64'(m_ir));
    chk("d_rdata", 64'(d_rdata), 64'(m_dr));
    chk("one_ack", 64'(i_ack & d_ack), 64'(0));
    if (m_req) begin
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_be", 64'(mem_be), 64'(m_be));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      if (m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
  end

  // memory: acks LAT cycles after mem_req rises unless disabled; stray injects a spurious ack
  bit mem_on = 1, stray = 0, m_hit = 0;
  int mcnt = 0;
  always @(negedge clk) begin
    m_hit = 0;
    if (mem_req && mem_on) begin
      mcnt++;
      if (mcnt == LAT + 1) begin m_hit = 1; mcnt = 0; end
    end else if (!mem_req) mcnt = 0;
    mem_ack = m_hit | stray;
    mem_rdata = (mem_addr == 32'h100) ? 32'h00500093 : {mem_addr[15:0], 16'hA5A5};
  end

  // observer for literal checks
  int cyc = 0, t_mack = 0, t_rise = 0, t_iack = 0, t_dack = 0, hi_len = 0;
  logic prev_mreq = 0;
  logic [31:0] l_ir = 0, l_dr = 0;
  logic [63:0] grants[$];
  always @(posedge clk) begin
    if (mem_ack && mem_req) t_mack = cyc;
    cyc++;
  end
  always @(negedge clk) begin
    if (mem_req && !prev_mreq) begin grants.push_back({31'b0, mem_we, mem_addr}); t_rise = cyc; end
    if (!mem_req && prev_mreq) hi_len = cyc - t_rise;
    prev_mreq = mem_req;
    if (i_ack) begin t_iack = cyc; l_ir = i_rdata; end
    if (d_ack) begin t_dack = cyc; l_dr = d_rdata; end
  end

  task automatic do_fetch(input logic [31:0] a);
    int n;
    n = 0;
    i_addr = a; i_req = 1;
    do begin @(negedge clk); n++; end while (!i_ack && n < 1000);
    chk("fetch_done", 64'(i_ack), 64'(1));
    i_req = 0;
  endtask

  task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    d_we = we; d_be = be; d_addr = a; d_wdata = wd; d_req = 1;
    do begin @(negedge clk); n++; end while (!d_ack && n < 1000);
    chk("data_done", 64'(d_ack), 64'(1));
    d_req = 0;
  endtask

  logic [31:0] exp39 [7] = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h140, 32'h810, 32'h814};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_acks", 64'({i_ack, d_ack}), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    rst = 0;
    @(negedge clk);
    // single fetch
    do_fetch(32'h100);
    @(negedge clk);
    chk("t037_rdata", 64'(l_ir), 64'h00500093);
    chk("t037_ack_lat", 64'(t_iack - t_mack), 64'(1));
    chk("t037_mem_lat", 64'(t_mack - t_rise), 64'(3));
    // simultaneous store and fetch
    grants.delete();
    fork
      do_data(1'b1, 4'hF, 32'h200, 32'hCAFEF00D);
      do_fetch(32'h104);
    join
    @(negedge clk);
    chk("t038_ngrants", 64'(grants.size()), 64'(2));
    chk("t038_first", grants[0], 64'h1_0000_0200);
    chk("t038_second", grants[1], 64'h0_0000_0104);
    chk("t038_order", 64'(t_dack < t_iack), 64'(1));
    // streak limit
    grants.delete();
    fork
      do_fetch(32'h140);
      begin
        for (int k = 0; k < 6; k++) do_data(1'b0, 4'h0, 32'h800 + 32'(4 * k), 32'h0);
      end
    join
    @(negedge clk);
    chk("t039_ngrants", 64'(grants.size()), 64'(7));
    for (int k = 0; k < 7; k++) chk($sformatf("t039_grant%0d", k), 64'(grants[k][31:0]), 64'(exp39[k]));
    // stray mem_ack while idle
    stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (2) @(negedge clk);
    chk("t042_acks", 64'({i_ack, d_ack}), 64'(0));
    chk("t042_mem_req", 64'(mem_req), 64'(0));
    do_fetch(32'h108);
    @(negedge clk);
    chk("t042_after", 64'(l_ir), 64'(32'h0108A5A5));
    // timeout
    mem_on = 0;
    do_data(1'b0, 4'h0, 32'h300, 32'h0);
    mem_on = 1;
    @(negedge clk);
    chk("t040_rdata", 64'(l_dr), 64'hDEADBEEF);
    chk("t040_err", 64'(err), 64'(1));
    chk("t040_hi_len", 64'(hi_len), 64'(TO));
    do_fetch(32'h10C);
    @(negedge clk);
    chk("t040_err_sticky", 64'(err), 64'(1));
    chk("t040_next", 64'(l_ir), 64'(32'h010CA5A5));
    // reset mid fetch
    mem_on = 0;
    i_addr = 32'h110; i_req = 1;
    for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk);
    chk("t041_started", 64'(mem_req), 64'(1));
    @(negedge clk);
    rst = 1; i_req = 0;
    @(negedge clk);
    chk("t041_mem_req", 64'(mem_req), 64'(0));
    chk("t041_acks", 64'({i_ack, d_ack}), 64'(0));
    chk("t041_err", 64'(err), 64'(0));
    chk("t041_data", 64'({i_rdata, d_rdata}), 64'(0));
    chk("t041_cmd", 64'({mem_we, mem_be, mem_addr}), 64'(0));
    rst = 0; mem_on = 1;
    repeat (3) @(negedge clk);
    chk("t041_no_ack", 64'({i_ack, d_ack, mem_req}), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
